axil_wr_router: RTL and testbench

- Write-direction counterpart of the interconnect's read-address path.
- Accepts one AXI-Lite write transaction (AW, W, B) from a single master port and decodes the address against per-slave regions.
- Forwards AW/W to the selected slave, returns that slave's B response.
- Completes unmapped writes locally with DECERR. One outstanding transaction at a time.

---
 rtl/axil_wr_router.sv | 249 ++++++++++++++++++++++++
 tb/tb_axil_wr_router.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_wr_router.sv
// AXI-Lite write router: one outstanding AW/W/B transaction, address decode to NUMBER_SLAVE regions, DECERR for unmapped writes.
// Optional watchdog on the slave-facing phases: define AXIL_WR_ROUTER_TIMEOUT_EN (returns SLVERR after TIMEOUT_CYCLES).
//
// state | meaning
// IDLE  | accepting master AW and W independently; decode once both are held
// FWD   | presenting AW/W to the selected slave until both handshakes complete
// RESP  | waiting for the selected slave's B response
// BRESP | holding the response on the master B channel until bready
module axil_wr_router #(
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] = '{default: '0},
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] = '{default: 1},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,

  input  logic [AXI_ADDR_WIDTH-1:0]                     m_axil_awaddr,
  input  logic                                          m_axil_awvalid,
  output logic                                          m_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]                     m_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]                   m_axil_wstrb,
  input  logic                                          m_axil_wvalid,
  output logic                                          m_axil_wready,
  output logic [1:0]                                    m_axil_bresp,
  output logic                                          m_axil_bvalid,
  input  logic                                          m_axil_bready,

  output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0]        s_axil_awaddr,
  output logic [NUMBER_SLAVE-1:0]                       s_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]                       s_axil_awready,
  output logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0]        s_axil_wdata,
  output logic [NUMBER_SLAVE*(AXI_DATA_WIDTH/8)-1:0]    s_axil_wstrb,
  output logic [NUMBER_SLAVE-1:0]                       s_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]                       s_axil_wready,
  input  logic [NUMBER_SLAVE*2-1:0]                     s_axil_bresp,
  input  logic [NUMBER_SLAVE-1:0]                       s_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]                       s_axil_bready
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int SEL_WIDTH  = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    RESP  = 2'd2,
    BRESP = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      aw_cap_q, aw_cap_d;
  logic                      w_cap_q, w_cap_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [1:0]                bresp_q, bresp_d;

  logic                      aw_hs, w_hs;
  logic                      s_aw_hs, s_w_hs, s_b_hs;
  logic [AXI_ADDR_WIDTH-1:0] dec_addr;
  logic                      dec_hit;
  logic [SEL_WIDTH-1:0]      dec_sel;
  logic [NUMBER_SLAVE-1:0]   sel_oh;
  logic [1:0]                sel_bresp;
  logic                      timeout;

  if (NUMBER_SLAVE < 1 || TIMEOUT_CYCLES < 1 || (AXI_DATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("axil_wr_router: illegal parameterisation");
  end

  assign aw_hs   = m_axil_awvalid & m_axil_awready;
  assign w_hs    = m_axil_wvalid & m_axil_wready;
  assign s_aw_hs = |(s_axil_awvalid & s_axil_awready);
  assign s_w_hs  = |(s_axil_wvalid & s_axil_wready);
  assign s_b_hs  = |(s_axil_bvalid & s_axil_bready);

  assign sel_oh    = NUMBER_SLAVE'(1) << sel_q;
  assign sel_bresp = s_axil_bresp[2*sel_q +: 2];

  // Decode the address being captured this cycle so a same-cycle AW+W can leave IDLE immediately.
  assign dec_addr = aw_hs ? m_axil_awaddr : addr_q;

  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUMBER_SLAVE - 1; i >= 0; i--) begin
      if (({1'b0, dec_addr} >= {1'b0, AXI_ADDR_OFFSET[i]}) &&
          ({1'b0, dec_addr} <  ({1'b0, AXI_ADDR_OFFSET[i]} + {1'b0, AXI_ADDR_RANGE[i]}))) begin
        dec_hit = 1'b1;
        dec_sel = SEL_WIDTH'(i);
      end
    end
  end

`ifdef AXIL_WR_ROUTER_TIMEOUT_EN
  localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_WIDTH-1:0] tmr_q, tmr_d;

  // Reloaded on every state change; terminal count is reached on the TIMEOUT_CYCLES-th cycle in FWD/RESP.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TMR_WIDTH'(1);
    end
  end

  assign timeout = ((state_q == FWD) || (state_q == RESP)) && (tmr_q == '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    sel_d     = sel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          addr_d   = m_axil_awaddr;
        end
        if (w_hs) begin
          w_cap_d = 1'b1;
          data_d  = m_axil_wdata;
          strb_d  = m_axil_wstrb;
        end
        if (aw_cap_d && w_cap_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (dec_hit) begin
            state_d = FWD;
            sel_d   = dec_sel;
          end else begin
            state_d = BRESP;
            bresp_d = RESP_DECERR;
          end
        end
      end
      FWD: begin
        if (s_aw_hs) aw_done_d = 1'b1;
        if (s_w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d = BRESP;
          bresp_d = RESP_SLVERR;
        end
      end
      RESP: begin
        if (s_b_hs) begin
          state_d = BRESP;
          bresp_d = sel_bresp;
        end else if (timeout) begin
          state_d = BRESP;
          bresp_d = RESP_SLVERR;
        end
      end
      BRESP: begin
        if (m_axil_bready) begin
          state_d  = IDLE;
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bvalid  = 1'b0;
    s_axil_awvalid = '0;
    s_axil_wvalid  = '0;
    s_axil_bready  = '0;
    case (state_q)
      IDLE: begin
        m_axil_awready = !aw_cap_q;
        m_axil_wready  = !w_cap_q;
      end
      FWD: begin
        if (!aw_done_q) s_axil_awvalid = sel_oh;
        if (!w_done_q)  s_axil_wvalid  = sel_oh;
      end
      RESP:    s_axil_bready = sel_oh;
      BRESP:   m_axil_bvalid = 1'b1;
      default: ;
    endcase
  end

  assign m_axil_bresp  = bresp_q;
  assign s_axil_awaddr = {NUMBER_SLAVE{addr_q}};
  assign s_axil_wdata  = {NUMBER_SLAVE{data_q}};
  assign s_axil_wstrb  = {NUMBER_SLAVE{strb_q}};

endmodule

// File: tb/tb_axil_wr_router.sv
// Directed bench for axil_wr_router: scoreboard of expected slave AW/W beats and master B responses.
`timescale 1ns/1ps
module tb_axil_wr_router;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  localparam logic [AW-1:0] OFFS [NS] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
  localparam logic [AW-1:0] RNGS [NS] = '{default: 32'h1000};

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [AW-1:0]     m_awaddr = '0;
  logic              m_awvalid = 1'b0;
  logic              m_awready;
  logic [DW-1:0]     m_wdata = '0;
  logic [SW-1:0]     m_wstrb = '0;
  logic              m_wvalid = 1'b0;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready = 1'b1;
  logic [NS*AW-1:0]  s_awaddr;
  logic [NS-1:0]     s_awvalid;
  logic [NS-1:0]     s_awready = '1;
  logic [NS*DW-1:0]  s_wdata;
  logic [NS*SW-1:0]  s_wstrb;
  logic [NS-1:0]     s_wvalid;
  logic [NS-1:0]     s_wready = '1;
  logic [NS*2-1:0]   s_bresp;
  logic [NS-1:0]     s_bvalid;
  logic [NS-1:0]     s_bready;

  axil_wr_router #(
    .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_OFFSET(OFFS), .AXI_ADDR_RANGE(RNGS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int sel; logic [AW-1:0] addr; } aw_exp_t;
  typedef struct { int sel; logic [DW-1:0] data; logic [SW-1:0] strb; } w_exp_t;
  aw_exp_t    aw_q[$];
  w_exp_t     w_q[$];
  logic [1:0] b_q[$];

  logic [NS-1:0] slave_silent = '0;
  logic [1:0]    slave_resp [NS] = '{default: 2'b00};
  logic [NS-1:0] aw_got, w_got;

  function automatic int model_sel(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ({1'b0, a} >= {1'b0, OFFS[i]} && {1'b0, a} < {1'b0, OFFS[i]} + {1'b0, RNGS[i]}) return i;
    return -1;
  endfunction

  // Slave models plus scoreboard check of every beat that reaches a slave.
  initial begin
    logic [NS-1:0] aw_hs, w_hs, b_hs;
    aw_exp_t ea;
    w_exp_t  ew;
    s_bvalid = '0;
    s_bresp  = '0;
    aw_got   = '0;
    w_got    = '0;
    forever begin
      @(negedge aclk);
      aw_hs = s_awvalid & s_awready;
      w_hs  = s_wvalid & s_wready;
      b_hs  = s_bvalid & s_bready;
      for (int i = 0; i < NS; i++) begin
        if (aw_hs[i]) begin
          if (aw_q.size() == 0) chk("slave_aw_unexpected", 64'(i), 64'hff);
          else begin
            ea = aw_q.pop_front();
            chk("slave_aw_sel", 64'(i), 64'(ea.sel));
            chk("slave_awaddr", s_awaddr[i*AW +: AW], ea.addr);
          end
        end
        if (w_hs[i]) begin
          if (w_q.size() == 0) chk("slave_w_unexpected", 64'(i), 64'hff);
          else begin
            ew = w_q.pop_front();
            chk("slave_w_sel", 64'(i), 64'(ew.sel));
            chk("slave_wdata", s_wdata[i*DW +: DW], ew.data);
            chk("slave_wstrb", s_wstrb[i*SW +: SW], ew.strb);
          end
        end
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        aw_got   = '0;
        w_got    = '0;
        s_bvalid = '0;
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (b_hs[i]) s_bvalid[i] = 1'b0;
          if (aw_hs[i]) aw_got[i] = 1'b1;
          if (w_hs[i])  w_got[i]  = 1'b1;
          if (aw_got[i] && w_got[i]) begin
            aw_got[i] = 1'b0;
            w_got[i]  = 1'b0;
            if (!slave_silent[i]) begin
              s_bvalid[i]       = 1'b1;
              s_bresp[i*2 +: 2] = slave_resp[i];
            end
          end
        end
      end
    end
  end

  // Issue one write; W may lead AW by w_lead cycles. Returns c0 = cycle AW is accepted. Ends at posedge+1 of cycle 1.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                      input int w_lead, input logic [1:0] exp_resp, output int c0);
    aw_exp_t ea;
    w_exp_t  ew;
    int      sel;
    sel = model_sel(a);
    if (sel >= 0) begin
      ea.sel = sel; ea.addr = a;
      ew.sel = sel; ew.data = d; ew.strb = s;
      aw_q.push_back(ea);
      w_q.push_back(ew);
    end
    b_q.push_back(exp_resp);
    @(posedge aclk);
    #1;
    m_wdata  = d;
    m_wstrb  = s;
    m_wvalid = 1'b1;
    if (w_lead > 0) begin
      @(negedge aclk);
      chk("w_early_ready", m_wready, 1);
      @(posedge aclk);
      #1;
      m_wvalid = 1'b0;
      for (int k = 1; k < w_lead; k++) begin
        @(negedge aclk);
        chk("w_early_idle", {m_awready, m_wready, s_awvalid, s_wvalid}, 10'b10_0000_0000);
        @(posedge aclk);
        #1;
      end
    end
    m_awaddr  = a;
    m_awvalid = 1'b1;
    c0 = cyc;
    @(negedge aclk);
    chk("aw_ready", m_awready, 1);
    if (w_lead == 0) chk("w_ready", m_wready, 1);
    @(posedge aclk);
    #1;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
  endtask

  // Called at a negedge. Waits for master bvalid, checks latency, optional bready hold, and the response.
  task automatic wait_b(input int c0, input int exp_lat, input int hold);
    int         n;
    logic [1:0] r0;
    logic [1:0] eb;
    n = 0;
    while (!m_bvalid && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!m_bvalid) begin
      chk("b_wait_expired", 0, 1);
      return;
    end
    chk("b_latency", 64'(cyc - c0), 64'(exp_lat));
    r0 = m_bresp;
    if (hold > 0) begin
      for (int k = 1; k < hold; k++) begin
        @(posedge aclk);
        #1;
        m_awaddr  = 32'h0000_0040;
        m_awvalid = 1'b1;
        m_wvalid  = 1'b1;
        @(negedge aclk);
        chk("hold_bvalid", m_bvalid, 1);
        chk("hold_bresp", m_bresp, r0);
        chk("hold_no_accept", {m_awready, m_wready}, 2'b00);
      end
      @(posedge aclk);
      #1;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b1;
      @(negedge aclk);
      chk("b_after_hold", m_bvalid, 1);
    end
    if (b_q.size() == 0) chk("b_unexpected", 64'(m_bresp), 64'hff);
    else begin
      eb = b_q.pop_front();
      chk("bresp", m_bresp, eb);
    end
    @(negedge aclk);
    chk("ready_reassert", {m_awready, m_wready, m_bvalid}, 3'b110);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c0;
    repeat (3) @(negedge aclk);
    chk("rst_ready", {m_awready, m_wready}, 2'b11);
    chk("rst_b", {m_bvalid, m_bresp}, 3'b000);
    chk("rst_slave_out", {s_awvalid, s_wvalid, s_bready}, 12'h000);
    aresetn = 1'b1;

    // Basic routed write to slave 1, zero-wait on both sides.
    send(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, c0);
    @(negedge aclk);
    chk("t1_awvalid", s_awvalid, 4'b0010);
    chk("t1_wvalid", s_wvalid, 4'b0010);
    wait_b(c0, 3, 0);

    // Slave 0 returns EXOKAY, partial strobe.
    slave_resp[0] = 2'b01;
    send(32'h0000_0010, 32'h0102_0304, 4'h3, 0, 2'b01, c0);
    @(negedge aclk);
    chk("t2_awvalid", s_awvalid, 4'b0001);
    wait_b(c0, 3, 0);

    // W leads AW by 3 cycles, last word of slave 3.
    send(32'h0000_3FFC, 32'hCAFE_F00D, 4'hC, 3, 2'b00, c0);
    @(negedge aclk);
    chk("t3_awvalid", s_awvalid, 4'b1000);
    wait_b(c0, 3, 0);

    // First unmapped address: DECERR with no slave activity.
    send(32'h0000_4000, 32'h1111_2222, 4'hF, 0, 2'b11, c0);
    @(negedge aclk);
    chk("t4_no_slave", {s_awvalid, s_wvalid}, 8'h00);
    wait_b(c0, 1, 0);

    // Slave 2 stalls awready for 5 cycles while taking W at once.
    s_awready[2] = 1'b0;
    slave_resp[2] = 2'b00;
    send(32'h0000_2008, 32'h1234_5678, 4'h6, 0, 2'b00, c0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge aclk);
      chk("t5_awvalid", s_awvalid, 4'b0100);
      chk("t5_wvalid", s_wvalid, (k == 1) ? 4'b0100 : 4'b0000);
      chk("t5_no_resp", s_bready, 4'b0000);
      @(posedge aclk);
      #1;
    end
    s_awready[2] = 1'b1;
    @(negedge aclk);
    chk("t5_aw_release", s_awvalid, 4'b0100);
    wait_b(c0, 8, 0);

    // Master holds bready low for 4 cycles while offering a new write.
    m_bready = 1'b0;
    send(32'h0000_2100, 32'hA5A5_5A5A, 4'hF, 0, 2'b00, c0);
    @(negedge aclk);
    wait_b(c0, 3, 4);

    // Reset while stuck in FWD: everything returns to reset values, no response.
    s_awready[1] = 1'b0;
    send(32'h0000_1000, 32'h0BAD_0BAD, 4'hF, 0, 2'b00, c0);
    @(negedge aclk);
    chk("t7_stuck", s_awvalid, 4'b0010);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t7_async_abort", {s_awvalid, s_wvalid, s_bready, m_bvalid, m_awready, m_wready}, 15'b0000_0000_0000_011);
    aw_q.delete();
    w_q.delete();
    b_q.delete();
    s_awready[1] = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("t7_no_b_after_reset", {m_bvalid, s_awvalid}, 5'b0_0000);
    end

`ifdef AXIL_WR_ROUTER_TIMEOUT_EN
    // Silent slave: watchdog answers SLVERR after TO cycles in RESP; next write completes normally.
    slave_silent[3] = 1'b1;
    send(32'h0000_3010, 32'h5555_AAAA, 4'hF, 0, 2'b10, c0);
    @(negedge aclk);
    wait_b(c0, 2 + TO, 0);
    slave_silent[3] = 1'b0;
    send(32'h0000_3020, 32'h7777_8888, 4'hF, 0, 2'b00, c0);
    @(negedge aclk);
    wait_b(c0, 3, 0);
`endif

    // Recovery after reset: a write to slave 1 still routes.
    send(32'h0000_1FFC, 32'h9999_0000, 4'h1, 0, 2'b00, c0);
    @(negedge aclk);
    chk("t9_awvalid", s_awvalid, 4'b0010);
    wait_b(c0, 3, 0);

    repeat (2) @(negedge aclk);
    chk("sb_drained", 64'(aw_q.size() + w_q.size() + b_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
